bin_to_fib: RTL

//  Converts an unsigned binary integer to its Zeckendorf (non-adjacent Fibonacci) code word.

---
 rtl/fib_pkg.sv | 35 +++
 rtl/fib_weight_down.sv | 34 +++
 rtl/bin_to_fib.sv | 115 +++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared Fibonacci-coding definitions: default widths, the fib() constant function,
// the largest value representable in a FIB_W-bit Zeckendorf word, and converter states.
package fib_pkg;

    localparam int FIB_W_DEF = 32;
    localparam int BIN_W_DEF = 22;

    // F(1) = F(2) = 1; F(n) for n <= 0 is treated as 0.
    function automatic int unsigned fib(input int n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        if (n <= 0) begin
            return 0;
        end
        for (int i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    // Code bits FIB_W-1..1 carry weights F(FIB_W)..F(2); all odd bits set gives F(FIB_W+1)-1.
    localparam int unsigned FIB_MAX = fib(FIB_W_DEF + 1) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OVF  = 2'd2
    } state_t;

endpackage

// File: rtl/fib_weight_down.sv
// Descending Fibonacci weight pair: load sets wa=F(FIB_W), wb=F(FIB_W-1); each step
// moves one position down the sequence using only a subtractor.
module fib_weight_down
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    output logic [BIN_W-1:0] wa,
    output logic [BIN_W-1:0] wb
);

    localparam logic [BIN_W-1:0] WA_INIT = BIN_W'(fib(FIB_W));
    localparam logic [BIN_W-1:0] WB_INIT = BIN_W'(fib(FIB_W - 1));

    // wa >= wb holds at every position down to F(2)/F(1), so wa-wb never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa <= '0;
            wb <= '0;
        end else if (load) begin
            wa <= WA_INIT;
            wb <= WB_INIT;
        end else if (step) begin
            wa <= wb;
            wb <= wa - wb;
        end
    end

endmodule

// File: rtl/bin_to_fib.sv
// Binary to Zeckendorf converter: greedy MSB-first search producing one code bit per clock.
// Bit k (k>=1) of fib_out has weight F(k+1); bit 0 is always 0.
module bin_to_fib
    import fib_pkg::*;
#(
    parameter int FIB_W = FIB_W_DEF,
    parameter int BIN_W = BIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_conv,
    input  logic [BIN_W-1:0] bin_in,
    output logic [FIB_W-1:0] fib_out,
    output logic             conv_done,
    output logic             busy,
    output logic             ovf
);

    localparam int              KW      = $clog2(FIB_W);
    localparam logic [KW-1:0]   K_TOP   = KW'(FIB_W - 1);
    localparam logic [KW-1:0]   K_LAST  = KW'(1);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(fib(FIB_W + 1) - 1);
    localparam logic [FIB_W-1:0] BIT0_CLR = ~FIB_W'(1);

    state_t           state;
    logic [BIN_W-1:0] rem;
    logic [FIB_W-1:0] acc;
    logic [KW-1:0]    k;
    logic [BIN_W-1:0] wa;
    logic [BIN_W-1:0] wb;

    logic             take;
    logic             in_range;
    logic             load;
    logic             step;
    logic [BIN_W-1:0] rem_next;
    logic [FIB_W-1:0] acc_next;

    fib_weight_down #(
        .FIB_W(FIB_W),
        .BIN_W(BIN_W)
    ) u_weights (
        .clk (clk),
        .rst (rst),
        .load(load),
        .step(step),
        .wa  (wa),
        .wb  (wb)
    );

    // Greedy order guarantees rem < F(k) after a take, so bit k-1 can never also set.
    always_comb begin
        take     = (rem >= wa);
        rem_next = take ? (rem - wa) : rem;
        acc_next = acc;
        if (take) begin
            acc_next[k] = 1'b1;
        end
        in_range = (bin_in <= MAX_BIN);
        load     = (state == IDLE) && en_conv && in_range;
        step     = (state == CONV);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rem       <= '0;
            acc       <= '0;
            k         <= '0;
            fib_out   <= '0;
            conv_done <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            conv_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_conv) begin
                        busy <= 1'b1;
                        if (in_range) begin
                            rem   <= bin_in;
                            acc   <= '0;
                            k     <= K_TOP;
                            state <= CONV;
                        end else begin
                            state <= OVF;
                        end
                    end
                end
                CONV: begin
                    rem <= rem_next;
                    acc <= acc_next;
                    k   <= k - 1'b1;
                    if (k == K_LAST) begin
                        fib_out   <= acc_next & BIT0_CLR;
                        conv_done <= 1'b1;
                        busy      <= 1'b0;
                        ovf       <= 1'b0;
                        state     <= IDLE;
                        assert (rem_next == '0);
                    end
                end
                OVF: begin
                    fib_out   <= '0;
                    ovf       <= 1'b1;
                    conv_done <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
